// File: rtl/bcd_stopwatch_timer.sv
// BCD stopwatch/timer: count-up or countdown in 0.1 s steps with preset load,
// lap-freeze display and a sticky done flag. Display digits are registered copies of the count.
module bcd_stopwatch_timer #(
  parameter int TICK_DIV   = 10_000_000,
  parameter int MIN_DIGITS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        clear,
  input  logic                        mode_down,
  input  logic                        load,
  input  logic [4*(MIN_DIGITS+3)-1:0] preset_bcd,
  input  logic                        lap,
  output logic [3:0]                  tenths_bcd,
  output logic [3:0]                  seconds_bcd,
  output logic [3:0]                  seconds2_bcd,
  output logic [4*MIN_DIGITS-1:0]     minutes_bcd,
  output logic                        running,
  output logic                        done,
  output logic                        lap_active
);

  localparam int DW   = 32'sd4;
  localparam int NDIG = MIN_DIGITS + 32'sd3;
  localparam int CW   = DW * NDIG;
  localparam int PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 32'sd1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

  // Digit index 2 is seconds tens, which rolls over at 5; all others roll at 9.
  function automatic logic [3:0] digit_max(input int idx);
    return (idx == 32'sd2) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [CW-1:0] count_max();
    logic [CW-1:0] v;
    v = {CW{1'b0}};
    for (int i = 32'sd0; i < NDIG; i++) v[DW*i +: DW] = digit_max(i);
    return v;
  endfunction

  function automatic logic [CW-1:0] clamp_preset(input logic [CW-1:0] p);
    logic [CW-1:0] v;
    v = p;
    for (int i = 32'sd0; i < NDIG; i++) begin
      if (p[DW*i +: DW] > digit_max(i)) v[DW*i +: DW] = digit_max(i);
      else v[DW*i +: DW] = p[DW*i +: DW];
    end
    return v;
  endfunction

  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] c);
    logic [CW-1:0] v;
    logic          carry;
    v     = c;
    carry = 1'b1;
    for (int i = 32'sd0; i < NDIG; i++) begin
      if (carry && (c[DW*i +: DW] >= digit_max(i))) begin
        v[DW*i +: DW] = 4'd0;
      end else if (carry) begin
        v[DW*i +: DW] = c[DW*i +: DW] + 4'd1;
        carry         = 1'b0;
      end else begin
        v[DW*i +: DW] = c[DW*i +: DW];
      end
    end
    return v;
  endfunction

  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] c);
    logic [CW-1:0] v;
    logic          borrow;
    v      = c;
    borrow = 1'b1;
    for (int i = 32'sd0; i < NDIG; i++) begin
      if (borrow && (c[DW*i +: DW] == 4'd0)) begin
        v[DW*i +: DW] = digit_max(i);
      end else if (borrow) begin
        v[DW*i +: DW] = c[DW*i +: DW] - 4'd1;
        borrow        = 1'b0;
      end else begin
        v[DW*i +: DW] = c[DW*i +: DW];
      end
    end
    return v;
  endfunction

  localparam logic [CW-1:0] COUNT_MAX = count_max();

  state_t          state_r, state_s;
  logic [CW-1:0]   count_r, count_s, step_s;
  logic [CW-1:0]   disp_r, disp_s;
  logic [PW-1:0]   presc_r, presc_s;
  logic            mode_r, mode_s;
  logic            done_r, done_s;
  logic            lap_r, lap_s;
  logic            running_r;

  // Next-state, count, prescaler and display selection; priority clear > stop > start > load.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    presc_s = presc_r;
    done_s  = done_r;
    lap_s   = lap_r;
    disp_s  = lap_r ? disp_r : count_r;
    step_s  = mode_r ? bcd_dec(count_r) : bcd_inc(count_r);
    mode_s  = (state_r == IDLE) ? mode_down : mode_r;
    if (clear) begin
      state_s = IDLE;
      count_s = {CW{1'b0}};
      presc_s = {PW{1'b0}};
      done_s  = 1'b0;
      lap_s   = 1'b0;
      disp_s  = {CW{1'b0}};
    end else begin
      // A lap snapshot takes the pre-tick count even when a tick lands on the same edge.
      if (lap && ((state_r == RUN) || (state_r == PAUSE))) begin
        lap_s  = ~lap_r;
        disp_s = count_r;
      end else begin
        lap_s  = lap_r;
      end
      case (state_r)
        IDLE: begin
          if (stop) begin
            state_s = IDLE;
          end else if (start) begin
            if (mode_down && (count_r == {CW{1'b0}})) state_s = IDLE;
            else state_s = RUN;
          end else if (load) begin
            count_s = clamp_preset(preset_bcd);
          end else begin
            count_s = count_r;
          end
        end
        RUN: begin
          if (presc_r == PRESC_LAST) begin
            presc_s = {PW{1'b0}};
            if (!mode_r && (count_r == COUNT_MAX)) begin
              done_s  = 1'b1;
              state_s = DONE;
            end else begin
              count_s = step_s;
              if (mode_r && (step_s == {CW{1'b0}})) begin
                done_s  = 1'b1;
                state_s = DONE;
              end else if (stop) begin
                state_s = PAUSE;
              end else begin
                state_s = RUN;
              end
            end
          end else begin
            presc_s = presc_r + PW'(1'b1);
            if (stop) state_s = PAUSE;
            else state_s = RUN;
          end
        end
        PAUSE: begin
          if (!stop && start) state_s = RUN;
          else state_s = PAUSE;
        end
        DONE: begin
          state_s = DONE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      count_r   <= {CW{1'b0}};
      disp_r    <= {CW{1'b0}};
      presc_r   <= {PW{1'b0}};
      mode_r    <= 1'b0;
      done_r    <= 1'b0;
      lap_r     <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      count_r   <= count_s;
      disp_r    <= disp_s;
      presc_r   <= presc_s;
      mode_r    <= mode_s;
      done_r    <= done_s;
      lap_r     <= lap_s;
      running_r <= (state_s == RUN);
    end
  end

  assign tenths_bcd   = disp_r[3:0];
  assign seconds_bcd  = disp_r[7:4];
  assign seconds2_bcd = disp_r[11:8];
  assign minutes_bcd  = disp_r[CW-1:12];
  assign running      = running_r;
  assign done         = done_r;
  assign lap_active   = lap_r;

endmodule

// File: tb/tb_bcd_stopwatch_timer.sv
// Bench for bcd_stopwatch_timer: directed vector table, hand-written reset sequence,
// then random stimulus checked against a model that keeps time as an integer count of tenths.
module tb_bcd_stopwatch_timer;

  localparam int TICK_DIV   = 4;
  localparam int MIN_DIGITS = 2;
  localparam int NDIG       = MIN_DIGITS + 3;
  localparam int CW         = 4 * NDIG;
  localparam int MAXV       = 600 * (10 ** MIN_DIGITS) - 1;

  typedef struct packed {
    logic          clear;
    logic          stop;
    logic          start;
    logic          load;
    logic          mode_down;
    logic          lap;
    logic [CW-1:0] preset;
  } in_t;

  typedef struct {
    string         name;
    in_t           in;
    int            hold;
    logic [CW-1:0] exp_disp;
    logic          exp_run;
    logic          exp_done;
    logic          exp_lap;
  } row_t;

  typedef struct packed {
    int val;
    int disp;
    int phase;
    bit run;
    bit pause;
    bit done;
    bit frozen;
    bit down;
  } model_t;

  logic                    clk   = 1'b0;
  logic                    reset = 1'b1;
  in_t                     drv   = '0;
  logic [3:0]              tenths_bcd, seconds_bcd, seconds2_bcd;
  logic [4*MIN_DIGITS-1:0] minutes_bcd;
  logic                    running, done, lap_active;
  model_t                  m;
  int                      checks = 0;
  int                      errors = 0;
  row_t                    rows [22];

  bcd_stopwatch_timer #(.TICK_DIV(TICK_DIV), .MIN_DIGITS(MIN_DIGITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (drv.start),
    .stop         (drv.stop),
    .clear        (drv.clear),
    .mode_down    (drv.mode_down),
    .load         (drv.load),
    .preset_bcd   (drv.preset),
    .lap          (drv.lap),
    .tenths_bcd   (tenths_bcd),
    .seconds_bcd  (seconds_bcd),
    .seconds2_bcd (seconds2_bcd),
    .minutes_bcd  (minutes_bcd),
    .running      (running),
    .done         (done),
    .lap_active   (lap_active)
  );

  always #5 clk = ~clk;

  function automatic int preset_to_tenths(logic [CW-1:0] p);
    int d [NDIG];
    int mins;
    for (int k = 0; k < NDIG; k++) begin
      d[k] = int'(p[4*k +: 4]);
      if (d[k] > 9) d[k] = 9;
    end
    if (d[2] > 5) d[2] = 5;
    mins = 0;
    for (int k = NDIG - 1; k >= 3; k--) mins = mins * 10 + d[k];
    return mins * 600 + d[2] * 100 + d[1] * 10 + d[0];
  endfunction

  function automatic logic [CW-1:0] to_bcd(int v);
    logic [CW-1:0] r;
    int mins;
    r = '0;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 6);
    mins = v / 600;
    for (int k = 3; k < NDIG; k++) begin
      r[4*k +: 4] = 4'(mins % 10);
      mins = mins / 10;
    end
    return r;
  endfunction

  function automatic model_t model_next(model_t c, in_t i);
    model_t n;
    bit idle;
    bit tick;
    n    = c;
    idle = !c.run && !c.pause && !c.done;
    n.disp = c.frozen ? c.disp : c.val;
    if (idle) n.down = i.mode_down;
    if (i.clear) begin
      n.val = 0; n.disp = 0; n.phase = 0;
      n.run = 0; n.pause = 0; n.done = 0; n.frozen = 0;
    end else begin
      if (i.lap && (c.run || c.pause)) begin
        n.frozen = !c.frozen;
        n.disp   = c.val;
      end
      if (c.run) begin
        tick    = (c.phase == TICK_DIV - 1);
        n.phase = tick ? 0 : c.phase + 1;
        if (tick && !c.down && c.val == MAXV) begin
          n.run = 0; n.done = 1;
        end else begin
          if (tick) n.val = c.down ? c.val - 1 : c.val + 1;
          if (tick && c.down && n.val == 0) begin
            n.run = 0; n.done = 1;
          end else if (i.stop) begin
            n.run = 0; n.pause = 1;
          end
        end
      end else if (c.pause) begin
        if (!i.stop && i.start) begin
          n.pause = 0; n.run = 1;
        end
      end else if (idle && !i.stop) begin
        if (i.start) begin
          if (!(i.mode_down && c.val == 0)) n.run = 1;
        end else if (i.load) begin
          n.val = preset_to_tenths(i.preset);
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else m <= model_next(m, drv);
  end

  function automatic logic [CW+2:0] dut_vec();
    return {minutes_bcd, seconds2_bcd, seconds_bcd, tenths_bcd, running, done, lap_active};
  endfunction

  task automatic check(input string name, input logic [CW+2:0] got, input logic [CW+2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got disp=%h run=%b done=%b lap=%b, expected disp=%h run=%b done=%b lap=%b",
               name, got[CW+2:3], got[2], got[1], got[0], exp[CW+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic row_t mk(string name, bit clr, bit stp, bit sta, bit ld, bit md, bit lp,
                              logic [CW-1:0] pre, int hold, logic [CW-1:0] ed,
                              bit er, bit edn, bit el);
    row_t r;
    r.name     = name;
    r.in       = '{clear: clr, stop: stp, start: sta, load: ld, mode_down: md, lap: lp, preset: pre};
    r.hold     = hold;
    r.exp_disp = ed;
    r.exp_run  = er;
    r.exp_done = edn;
    r.exp_lap  = el;
    return r;
  endfunction

  task automatic apply_row(input row_t r);
    drv = r.in;
    @(negedge clk);
    drv.clear = 1'b0; drv.stop = 1'b0; drv.start = 1'b0; drv.load = 1'b0; drv.lap = 1'b0;
    repeat (r.hold) @(negedge clk);
    check(r.name, dut_vec(), {r.exp_disp, r.exp_run, r.exp_done, r.exp_lap});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    //                name            clr stp sta ld md lp preset       hold disp        run done lap
    rows[0]  = mk("load_0598",      0,  0,  0,  1, 0, 0, 20'h00598,   1, 20'h00598, 0, 0, 0);
    rows[1]  = mk("up_carry",       0,  0,  1,  0, 0, 0, 20'h00000,   9, 20'h01000, 1, 0, 0);
    rows[2]  = mk("clear_start",    1,  0,  1,  0, 0, 0, 20'h00000,   1, 20'h00000, 0, 0, 0);
    rows[3]  = mk("load_dn3",       0,  0,  0,  1, 1, 0, 20'h00003,   1, 20'h00003, 0, 0, 0);
    rows[4]  = mk("dn_done",        0,  0,  1,  0, 1, 0, 20'h00000,  13, 20'h00000, 0, 1, 0);
    rows[5]  = mk("done_hold",      0,  1,  1,  0, 1, 0, 20'h00000,  20, 20'h00000, 0, 1, 0);
    rows[6]  = mk("clear_done",     1,  0,  0,  0, 1, 0, 20'h00000,   0, 20'h00000, 0, 0, 0);
    rows[7]  = mk("dn_zero_start",  0,  0,  1,  0, 1, 0, 20'h00000,   2, 20'h00000, 0, 0, 0);
    rows[8]  = mk("clamp_load",     0,  0,  0,  1, 0, 0, 20'hCA7BC,   1, 20'h99599, 0, 0, 0);
    rows[9]  = mk("load_sat",       0,  0,  0,  1, 0, 0, 20'h99598,   1, 20'h99598, 0, 0, 0);
    rows[10] = mk("sat_tick",       0,  0,  1,  0, 0, 0, 20'h00000,   5, 20'h99599, 1, 0, 0);
    rows[11] = mk("sat_done",       0,  0,  0,  0, 0, 0, 20'h00000,   4, 20'h99599, 0, 1, 0);
    rows[12] = mk("clear_sat",      1,  0,  0,  0, 0, 0, 20'h00000,   1, 20'h00000, 0, 0, 0);
    rows[13] = mk("pause_start",    0,  0,  1,  0, 0, 0, 20'h00000,   1, 20'h00000, 1, 0, 0);
    rows[14] = mk("pause_stop",     0,  1,  0,  0, 0, 0, 20'h00000,  10, 20'h00000, 0, 0, 0);
    rows[15] = mk("pause_resume",   0,  0,  1,  0, 0, 0, 20'h00000,   2, 20'h00000, 1, 0, 0);
    rows[16] = mk("pause_tick",     0,  0,  0,  0, 0, 0, 20'h00000,   0, 20'h00001, 1, 0, 0);
    rows[17] = mk("lap_clear",      1,  0,  0,  0, 0, 0, 20'h00000,   1, 20'h00000, 0, 0, 0);
    rows[18] = mk("lap_load",       0,  0,  0,  1, 0, 0, 20'h00010,   1, 20'h00010, 0, 0, 0);
    rows[19] = mk("lap_run",        0,  0,  1,  0, 0, 0, 20'h00000,   8, 20'h00011, 1, 0, 0);
    rows[20] = mk("lap_freeze",     0,  0,  0,  0, 0, 1, 20'h00000,  20, 20'h00012, 1, 0, 1);
    rows[21] = mk("lap_release",    0,  0,  0,  0, 0, 1, 20'h00000,   0, 20'h00017, 1, 0, 0);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_state", dut_vec(), '0);

    for (int r = 0; r < 22; r++) apply_row(rows[r]);

    // Asynchronous reset while running: outputs must clear before the next clock edge.
    #2 reset = 1'b1;
    #1 check("async_reset", dut_vec(), '0);
    @(negedge clk);
    reset = 1'b0;
    check("reset_held", dut_vec(), '0);
    @(negedge clk);
    check("after_reset", dut_vec(), '0);

    for (int n = 0; n < 4000; n++) begin
      drv.clear = ($urandom_range(0, 149) == 0);
      drv.stop  = ($urandom_range(0, 19) == 0);
      drv.start = ($urandom_range(0, 5) == 0);
      drv.load  = ($urandom_range(0, 4) == 0);
      drv.lap   = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 15) == 0) drv.mode_down = !drv.mode_down;
      case ($urandom_range(0, 3))
        0:       drv.preset = {12'h000, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
        1:       drv.preset = {8'h99, 4'h5, 4'h9, 4'($urandom_range(7, 15))};
        default: drv.preset = 20'($urandom());
      endcase
      @(negedge clk);
      check("random", dut_vec(), {to_bcd(m.disp), m.run, m.done, m.frozen});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
